// File: rtl/axis_tx_frame_buffer.sv
// Store-and-forward AXI-Stream frame buffer between the GMII-to-AXI packer and the 10G MAC TX.
// Define DROP_ON_FULL_EN to drop overflowing frames instead of backpressuring upstream.
module axis_tx_frame_buffer #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic            tx_clk_out,
  input  logic            sys_reset,
  input  logic            s_axis_tvalid,
  input  logic [63:0]     s_axis_tdata,
  input  logic [7:0]      s_axis_tkeep,
  input  logic            s_axis_tlast,
  output logic            s_axis_tready,
  output logic            m_axis_tvalid,
  output logic [63:0]     m_axis_tdata,
  output logic [7:0]      m_axis_tkeep,
  output logic            m_axis_tlast,
  input  logic            m_axis_tready,
  output logic [ADDR_W:0] frame_cnt,
  output logic [15:0]     drop_cnt,
  output logic            ovf_pulse
);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 73;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;
  state_t r_state, w_state_nxt;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic              r_rst_done;
  logic              r_s1_valid, r_m_valid;
  logic [WORD_W-1:0] r_s1_data, r_m_data;
  logic [PTR_W-1:0]  r_frame_cnt;
  logic [15:0]       r_drop_cnt;
  logic              r_ovf;

  logic w_full, w_oversize, w_ready, w_accept, w_overflow;
  logic w_wr_en, w_commit, w_rollback;
  logic w_out_ready, w_s1_ready, w_rd_en, w_tx_last;
  logic [PTR_W-1:0] w_wr_ptr_inc;

  assign w_full       = (r_wr_ptr - r_rd_ptr) == PTR_W'(DEPTH);
  assign w_oversize   = (r_state == S_WRITE) && ((r_wr_ptr - r_commit_ptr) == PTR_W'(DEPTH));
  assign w_wr_ptr_inc = r_wr_ptr + PTR_W'(1);

`ifdef DROP_ON_FULL_EN
  assign w_ready    = r_rst_done;
  assign w_overflow = w_oversize || (w_accept && w_full && (r_state != S_DROP));
`else
  // DROP must keep accepting so an oversize frame can be flushed even though RAM is full
  assign w_ready    = r_rst_done && ((r_state == S_DROP) || !w_full);
  assign w_overflow = w_oversize;
`endif

  assign w_accept = s_axis_tvalid && w_ready;

  always_ff @(posedge tx_clk_out or posedge sys_reset) begin
    if (sys_reset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !s_axis_tlast) w_state_nxt = S_WRITE;
      S_WRITE: if (w_accept && s_axis_tlast)  w_state_nxt = S_IDLE;
      S_DROP:  if (w_accept && s_axis_tlast)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_overflow) w_state_nxt = (w_accept && s_axis_tlast) ? S_IDLE : S_DROP;
  end

  always_comb begin
    w_wr_en    = 1'b0;
    w_commit   = 1'b0;
    w_rollback = 1'b0;
    if (w_overflow) begin
      w_rollback = 1'b1;
    end else if (w_accept && (r_state != S_DROP)) begin
      w_wr_en  = 1'b1;
      w_commit = s_axis_tlast;
    end
  end

  // Two-stage read pipeline: registered RAM read (s1) feeding the output register
  assign w_out_ready = !r_m_valid || m_axis_tready;
  assign w_s1_ready  = !r_s1_valid || w_out_ready;
  assign w_rd_en     = (r_rd_ptr != r_commit_ptr) && w_s1_ready;
  assign w_tx_last   = r_m_valid && m_axis_tready && r_m_data[WORD_W-1];

  always_ff @(posedge tx_clk_out) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge tx_clk_out or posedge sys_reset) begin
    if (sys_reset) begin
      r_rst_done   <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_frame_cnt  <= '0;
      r_drop_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_rollback)   r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en) r_wr_ptr <= w_wr_ptr_inc;
      if (w_commit) r_commit_ptr <= w_wr_ptr_inc;
      if (w_commit != w_tx_last)
        r_frame_cnt <= w_commit ? (r_frame_cnt + PTR_W'(1)) : (r_frame_cnt - PTR_W'(1));
      r_ovf <= w_rollback;
      if (w_rollback && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_rd_en) begin
        r_s1_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
      end
      if (w_s1_ready) r_s1_valid <= w_rd_en;
      if (w_out_ready) begin
        r_m_valid <= r_s1_valid;
        if (r_s1_valid) r_m_data <= r_s1_data;
      end
    end
  end

  assign s_axis_tready = w_ready;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data[63:0];
  assign m_axis_tkeep  = r_m_data[71:64];
  assign m_axis_tlast  = r_m_data[72];
  assign frame_cnt     = r_frame_cnt;
  assign drop_cnt      = r_drop_cnt;
  assign ovf_pulse     = r_ovf;

endmodule

// File: tb/tb_axis_tx_frame_buffer.sv
// Self-checking bench for axis_tx_frame_buffer: directed steps plus random frames against a queue model.
module tb_axis_tx_frame_buffer;
  localparam int unsigned AW = 4;

  logic          clk, rst;
  logic          s_tvalid, s_tready, s_tlast;
  logic [63:0]   s_tdata;
  logic [7:0]    s_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [AW:0]   frame_cnt;
  logic [15:0]   drop_cnt;
  logic          ovf_pulse;

  int n_cmp, n_bad;
  int rx_cnt, ovf_seen, exp_drops, sink_mode;
  logic [72:0] exp_q[$];
  logic tog;

  axis_tx_frame_buffer #(.ADDR_W(AW)) dut (
    .tx_clk_out(clk), .sys_reset(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .ovf_pulse(ovf_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sink: 0 stalled, 1 always ready, 2 toggling, 3 random
  initial begin
    m_tready = 1'b0;
    tog = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (sink_mode)
        0: m_tready = 1'b0;
        1: m_tready = 1'b1;
        2: begin tog = ~tog; m_tready = tog; end
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: ordering/content against the model, stall stability, no intra-frame gaps
  initial begin
    logic [72:0] got, hold_w, e;
    bit in_frame, stalled;
    in_frame = 0;
    stalled = 0;
    hold_w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
        stalled = 0;
      end else begin
        got = {m_tlast, m_tkeep, m_tdata};
        if (stalled) begin
          check("stall_valid", 80'(m_tvalid), 80'(1));
          check("stall_hold", 80'(got), 80'(hold_w));
        end else if (in_frame) begin
          check("no_gap", 80'(m_tvalid), 80'(1));
        end
        if (m_tvalid && m_tready) begin
          n_cmp++;
          assert (exp_q.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_beat observed=%0h expected=none", got);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", 80'(got), 80'(e));
          end
          rx_cnt++;
          in_frame = !m_tlast;
        end
        stalled = m_tvalid && !m_tready;
        hold_w = got;
        if (ovf_pulse) ovf_seen++;
      end
    end
  end

  task automatic send_frame(input int len, input bit keep_exp, input bit gaps, input bit full_keep);
    logic [72:0] w;
    int t;
    for (int i = 0; i < len; i++) begin
      w[63:0]  = {$urandom, $urandom};
      w[71:64] = (i == len - 1 && !full_keep) ? 8'($urandom_range(1, 255)) : 8'hFF;
      w[72]    = (i == len - 1);
      if (keep_exp) exp_q.push_back(w);
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = w[63:0];
      s_tkeep  = w[71:64];
      s_tlast  = w[72];
      t = 0;
      @(negedge clk);
      while (!s_tready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!s_tready) check("accept_timeout", 80'(s_tready), 80'(1));
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, 80'(exp_q.size()), 80'(0));
  endtask

  initial begin
    int rx0, nexp, len, maxlen;
    logic [7:0] lastpat;
    n_cmp = 0; n_bad = 0; rx_cnt = 0; ovf_seen = 0; exp_drops = 0;
    sink_mode = 1;
    rst = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    lastpat = 8'b1100_0010;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 80'(m_tvalid), 80'(0));
    check("rst_tdata", 80'({m_tlast, m_tkeep, m_tdata}), 80'(0));
    check("rst_frame_cnt", 80'(frame_cnt), 80'(0));
    check("rst_drop_cnt", 80'(drop_cnt), 80'(0));
    check("rst_ovf", 80'(ovf_pulse), 80'(0));
    check("rst_tready", 80'(s_tready), 80'(0));
    rst = 1'b0;
    #1 check("tready_before_edge", 80'(s_tready), 80'(0));
    @(posedge clk); #1;
    check("tready_after_edge", 80'(s_tready), 80'(1));

    // Single 8-beat frame: tvalid two cycles after the commit edge
    rx0 = rx_cnt;
    send_frame(8, 1, 0, 1);
    check("single_frame_cnt_commit", 80'(frame_cnt), 80'(1));
    check("single_tvalid_e0", 80'(m_tvalid), 80'(0));
    @(posedge clk); #1;
    check("single_tvalid_e1", 80'(m_tvalid), 80'(0));
    @(posedge clk); #1;
    check("single_tvalid_e2", 80'(m_tvalid), 80'(1));
    wait_drain("single_drain");
    check("single_beats", 80'(rx_cnt - rx0), 80'(8));
    check("single_frame_cnt_end", 80'(frame_cnt), 80'(0));

    // Backpressure with toggling sink
    sink_mode = 2;
    rx0 = rx_cnt;
    send_frame(3, 1, 0, 0);
    wait_drain("bp_drain");
    check("bp_beats", 80'(rx_cnt - rx0), 80'(3));

    // Back-to-back frames 2/5/1 released together
    sink_mode = 0;
    @(posedge clk); #1;
    send_frame(2, 1, 0, 0);
    send_frame(5, 1, 0, 0);
    send_frame(1, 1, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("b2b_frame_cnt", 80'(frame_cnt), 80'(3));
    sink_mode = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_valid%0d", i), 80'(m_tvalid), 80'(1));
      check($sformatf("b2b_last%0d", i), 80'(m_tlast), 80'(lastpat[i]));
    end
    @(posedge clk); #1;
    wait_drain("b2b_drain");

    // Overflow while the sink is stalled
    sink_mode = 0;
    @(posedge clk); #1;
    send_frame(10, 1, 0, 0);
`ifdef DROP_ON_FULL_EN
    send_frame(10, 0, 0, 0);
    exp_drops++;
    repeat (2) begin @(posedge clk); #1; end
    check("ovf_drop_cnt_stalled", 80'(drop_cnt), 80'(exp_drops));
    sink_mode = 1;
`else
    fork
      send_frame(10, 1, 0, 0);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("full_backpressure", 80'(s_tready), 80'(0));
        @(posedge clk); #1;
        sink_mode = 1;
      end
    join
`endif
    wait_drain("ovf_drain");
    check("ovf_drop_cnt", 80'(drop_cnt), 80'(exp_drops));
    check("ovf_pulses", 80'(ovf_seen), 80'(exp_drops));

    // Oversize frame is dropped; following frame still delivered
    sink_mode = 1;
    send_frame(20, 0, 0, 0);
    exp_drops++;
    send_frame(3, 1, 0, 0);
    wait_drain("oversize_drain");
    check("oversize_drop_cnt", 80'(drop_cnt), 80'(exp_drops));
    check("oversize_pulses", 80'(ovf_seen), 80'(exp_drops));

    // Random frames, random gaps and sink
`ifdef DROP_ON_FULL_EN
    sink_mode = 1;
    maxlen = 5;
`else
    sink_mode = 3;
    maxlen = 8;
`endif
    rx0 = rx_cnt;
    nexp = 0;
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, maxlen));
      nexp += len;
      send_frame(len, 1, 1, 0);
    end
    wait_drain("rand_drain");
    check("rand_beats", 80'(rx_cnt - rx0), 80'(nexp));
    check("rand_drop_cnt", 80'(drop_cnt), 80'(exp_drops));
    check("rand_frame_cnt", 80'(frame_cnt), 80'(0));

    // Reset during the third output beat
    sink_mode = 1;
    rx0 = rx_cnt;
    send_frame(5, 1, 0, 0);
    for (int t = 0; t < 100 && (rx_cnt - rx0) < 2; t++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    check("mid_beat3_valid", 80'(m_tvalid), 80'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 80'(m_tvalid), 80'(0));
    check("mid_rst_tdata", 80'({m_tlast, m_tkeep, m_tdata}), 80'(0));
    check("mid_rst_frame_cnt", 80'(frame_cnt), 80'(0));
    check("mid_rst_tready", 80'(s_tready), 80'(0));
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_drop_cnt", 80'(drop_cnt), 80'(0));
    rx0 = rx_cnt;
    send_frame(1, 1, 0, 0);
    wait_drain("post_rst_drain");
    check("post_rst_beats", 80'(rx_cnt - rx0), 80'(1));
    check("post_rst_frame_cnt", 80'(frame_cnt), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_tx_frame_buffer.md
AXIS_TX_FRAME_BUFFER -- requirements
Module: axis_tx_frame_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, which is the log2 of the buffer depth in 64-bit words (512 words).
REQ-002 SHALL have port tx_clk_out  input  1  sole clock; 156.25 MHz MAC TX user clock.
REQ-003 SHALL have port sys_reset  input  1  asynchronous active-high reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port s_axis_tvalid  input  1  upstream beat valid, from the GMII-to-AXI packer.
REQ-005 SHALL have port s_axis_tdata  input  64  upstream beat data.
REQ-006 SHALL have port s_axis_tkeep  input  8  upstream byte enables.
REQ-007 SHALL have port s_axis_tlast  input  1  upstream last beat of frame.
REQ-008 SHALL have port s_axis_tready  output  1  upstream ready.
REQ-009 SHALL have ports m_axis_tvalid/tdata/tkeep/tlast  output  1/64/8/1  stream to the 10G MAC TX.
REQ-010 SHALL have port m_axis_tready  input  1  MAC TX ready.
REQ-011 SHALL have port frame_cnt  output  ADDR_W+1  number of complete frames stored.
REQ-012 SHALL have port drop_cnt  output  16  count of dropped frames, saturating at 0xFFFF.
REQ-013 SHALL have port ovf_pulse  output  1  one-cycle pulse when a frame is dropped.

Function
REQ-014 SHALL operate store-and-forward: a frame becomes readable only after its tlast beat is written.
REQ-015 SHALL store each beat as one {tlast, tkeep, tdata} word.
- Write occurs when s_axis_tvalid && s_axis_tready.
- Beats are stored unmodified.
REQ-016 SHALL keep three pointers, each ADDR_W+1 bits with a wrap bit:
- wr_ptr: next write.
- commit_ptr: start of the frame being written.
- rd_ptr: next read.
REQ-017 SHALL define full as (wr_ptr - rd_ptr) == 2^ADDR_W; writes are never performed when full.
REQ-018 SHALL run a write FSM with states IDLE, WRITE, DROP.
- IDLE->WRITE on the first accepted beat without tlast.
- WRITE->IDLE on an accepted tlast beat.
- Any state->DROP on an overflow condition (REQ-025).
- DROP->IDLE on a tlast beat.
REQ-019 SHALL, on an accepted tlast beat in IDLE or WRITE, set commit_ptr to wr_ptr+1 and increment frame_cnt in the same edge.
REQ-020 SHALL assert m_axis_tvalid exactly 2 cycles after the commit edge when the buffer was otherwise empty (registered RAM read).
REQ-021 SHALL keep m_axis_tvalid continuously high from the first beat of a frame through its tlast handshake, with no gaps inside a frame.
REQ-022 SHALL hold m_axis_tdata/tkeep/tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-023 SHALL start back-to-back frames with no idle cycle when the next frame is already committed.
REQ-024 SHALL decrement frame_cnt on an m_axis tlast handshake; a simultaneous commit and tlast handshake leaves frame_cnt unchanged.
REQ-025 SHALL treat an overflow condition as a write attempted while full in WRITE, or a frame longer than 2^ADDR_W words; behaviour is given in Configuration.
REQ-026 SHALL assert ovf_pulse for exactly one cycle per dropped frame, on the drop-decision edge, and increment drop_cnt on the same edge, saturating.
REQ-027 SHALL ensure a dropped frame never appears, even partially, on m_axis.

Reset
REQ-028 SHALL, while sys_reset=1, asynchronously clear all of the following to 0 and set the FSM to IDLE:
- pointers, frame_cnt, drop_cnt, ovf_pulse;
- m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast.
REQ-029 SHALL drive s_axis_tready=0 during reset and 1 on the first edge after release.
REQ-030 SHALL discard any partial frame in flight on either side when reset is applied; a partial frame is not counted as dropped.

Configuration
REQ-031 SHALL use macro DROP_ON_FULL_EN to select overflow handling.
- Defined: s_axis_tready is held at 1 outside reset. On overflow, wr_ptr rolls back to commit_ptr, the FSM enters DROP, and the remaining beats through tlast are discarded.
- Undefined: s_axis_tready = !full, which backpressures upstream. The oversize-frame case (wr_ptr - commit_ptr == 2^ADDR_W with no tlast) still rolls back and enters DROP, preventing deadlock.

Verification
REQ-032 SHALL cover single frame: a 64-byte frame (8 beats, last tkeep=0xFF) -> m_axis_tvalid high 2 cycles after the tlast edge, 8 contiguous beats identical to input, frame_cnt 1->0.
REQ-033 SHALL cover backpressure: m_axis_tready toggled 1010 during a 3-beat frame -> data held stable while stalled, no beat lost or duplicated, tvalid never drops mid-frame.
REQ-034 SHALL cover back-to-back frames: 3 frames of 2, 5 and 1 beats written back-to-back, sink always ready -> 8 output beats with no idle cycle between frames, tlast on beats 2, 7 and 8.
REQ-035 SHALL cover overflow with DROP_ON_FULL_EN: ADDR_W=4, a 10-beat frame committed, then a 10-beat frame while the sink is stalled -> second frame dropped, ovf_pulse=1 for one cycle, drop_cnt=1, only the first frame emitted.
REQ-036 SHALL cover overflow without DROP_ON_FULL_EN: same stimulus -> s_axis_tready=0 at 16 words, both frames delivered intact once the sink is released, drop_cnt=0.
REQ-037 SHALL cover reset mid-frame: sys_reset asserted during beat 3 of output -> all outputs 0 immediately, frame_cnt=0; a new 1-beat frame after release is delivered normally.
